// File: rtl/adc_clear_replay.sv
// ---------------------------------------------------------------------------
// adc_clear_replay
//
// Three small, independent helpers that share one clock:
//   * a fake ADC sample counter advanced by adc_strobe,
//   * a memory-clear engine that takes one fill byte from the UART receiver
//     and writes it to all 256 addresses of an external memory,
//   * a UART replayer that echoes every received byte back to the
//     transmitter until it has echoed 0x04 (EOT).
//
// Build option:
//   FAKE_ADC_TRIANGLE_EN  defined   -> adc_data is a triangle 0x00..0xFF..0x00
//                                      (period 510 strobes)
//                         undefined -> adc_data is a sawtooth (0xFF -> 0x00)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous reset, active low
//   adc_strobe    advance the fake ADC sample by one step
//   adc_data[7:0] fake ADC sample
//   clr_activate  level enable for the clear engine
//   clr_done      clear finished (held while clr_activate stays high)
//   clr_mem_clk   memory write clock
//   clr_mem_we    memory write enable
//   clr_mem_addr  memory write address
//   clr_mem_data  memory write data
//   rep_activate  level enable for the replayer
//   rep_done      replay finished (held while rep_activate stays high)
//   rx_data[7:0]  received UART byte
//   rx_ready      received byte valid (only its rising edge is used)
//   tx_data[7:0]  byte to transmit
//   tx_start      one-cycle transmit request
//   tx_active     UART transmitter busy
//   tx_done       one-cycle end-of-byte pulse from the transmitter
// ---------------------------------------------------------------------------
module adc_clear_replay (
    input  logic       clk,
    input  logic       reset,
    input  logic       adc_strobe,
    output logic [7:0] adc_data,
    input  logic       clr_activate,
    output logic       clr_done,
    output logic       clr_mem_clk,
    output logic       clr_mem_we,
    output logic [7:0] clr_mem_addr,
    output logic [7:0] clr_mem_data,
    input  logic       rep_activate,
    output logic       rep_done,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_active,
    input  logic       tx_done
);

    // -----------------------------------------------------------------------
    // Fake ADC
    // -----------------------------------------------------------------------
    logic [7:0] adc_reg;

`ifdef FAKE_ADC_TRIANGLE_EN
    // Direction flag: 0 = counting up, 1 = counting down. The peaks 0xFF and
    // 0x00 are each visited once per period, giving 510 strobes per period.
    logic adc_down_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            adc_reg      <= 8'h00;
            adc_down_reg <= 1'b0;
        end else if (adc_strobe) begin
            if (!adc_down_reg) begin
                if (adc_reg == 8'hFF) begin
                    adc_reg      <= 8'hFE;
                    adc_down_reg <= 1'b1;
                end else begin
                    adc_reg <= adc_reg + 8'd1;
                end
            end else begin
                if (adc_reg == 8'h00) begin
                    adc_reg      <= 8'h01;
                    adc_down_reg <= 1'b0;
                end else begin
                    adc_reg <= adc_reg - 8'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset) begin
            adc_reg <= 8'h00;
        end else if (adc_strobe) begin
            adc_reg <= adc_reg + 8'd1;
        end
    end
`endif

    assign adc_data = adc_reg;

    // -----------------------------------------------------------------------
    // rx_ready rising-edge detector, shared by both engines. A byte held
    // valid for several cycles produces only one accept.
    // -----------------------------------------------------------------------
    logic rx_ready_d_reg;
    logic rx_rise;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_ready_d_reg <= 1'b0;
        end else begin
            rx_ready_d_reg <= rx_ready;
        end
    end

    assign rx_rise = rx_ready & ~rx_ready_d_reg;

    // -----------------------------------------------------------------------
    // Memory-clear engine
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        CLR_IDLE,
        CLR_WAIT_FILL,
        CLR_SETUP,
        CLR_STROBE,
        CLR_DONE
    } clr_state_t;

    clr_state_t clr_state_reg, clr_state_next;
    logic [7:0] clr_addr_reg, clr_addr_next;
    logic [7:0] clr_fill_reg, clr_fill_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            clr_state_reg <= CLR_IDLE;
            clr_addr_reg  <= 8'h00;
            clr_fill_reg  <= 8'h00;
        end else begin
            clr_state_reg <= clr_state_next;
            clr_addr_reg  <= clr_addr_next;
            clr_fill_reg  <= clr_fill_next;
        end
    end

    always_comb begin
        clr_state_next = clr_state_reg;
        clr_addr_next  = clr_addr_reg;
        clr_fill_next  = clr_fill_reg;
        clr_done       = 1'b0;
        clr_mem_clk    = 1'b0;
        clr_mem_we     = 1'b0;
        clr_mem_addr   = 8'h00;
        clr_mem_data   = 8'h00;

        // Address and data are only presented while a write is in progress,
        // so an aborted or idle engine drives all-zero outputs.
        case (clr_state_reg)
            CLR_SETUP: begin
                clr_mem_we   = 1'b1;
                clr_mem_addr = clr_addr_reg;
                clr_mem_data = clr_fill_reg;
            end
            CLR_STROBE: begin
                clr_mem_we   = 1'b1;
                clr_mem_clk  = 1'b1;
                clr_mem_addr = clr_addr_reg;
                clr_mem_data = clr_fill_reg;
            end
            CLR_DONE: begin
                clr_done = 1'b1;
            end
            default: ;
        endcase

        if (!clr_activate) begin
            // Abort from any state; a later activation must wait for a
            // fresh fill byte.
            clr_state_next = CLR_IDLE;
            clr_addr_next  = 8'h00;
            clr_fill_next  = 8'h00;
        end else begin
            case (clr_state_reg)
                CLR_IDLE: begin
                    clr_state_next = CLR_WAIT_FILL;
                end
                CLR_WAIT_FILL: begin
                    if (rx_rise) begin
                        clr_fill_next  = rx_data;
                        clr_addr_next  = 8'h00;
                        clr_state_next = CLR_SETUP;
                    end
                end
                CLR_SETUP: begin
                    clr_state_next = CLR_STROBE;
                end
                CLR_STROBE: begin
                    // Stop on the last address instead of letting the
                    // counter wrap back to 0x00.
                    if (clr_addr_reg == 8'hFF) begin
                        clr_state_next = CLR_DONE;
                    end else begin
                        clr_addr_next  = clr_addr_reg + 8'd1;
                        clr_state_next = CLR_SETUP;
                    end
                end
                CLR_DONE: begin
                    clr_state_next = CLR_DONE;
                end
                default: begin
                    clr_state_next = CLR_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // UART replayer
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        REP_IDLE,
        REP_WAIT_RX,
        REP_WAIT_IDLE,
        REP_START,
        REP_WAIT_DONE,
        REP_DONE
    } rep_state_t;

    rep_state_t rep_state_reg, rep_state_next;
    logic [7:0] tx_byte_reg, tx_byte_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_state_reg <= REP_IDLE;
            tx_byte_reg   <= 8'h00;
        end else begin
            rep_state_reg <= rep_state_next;
            tx_byte_reg   <= tx_byte_next;
        end
    end

    always_comb begin
        rep_state_next = rep_state_reg;
        tx_byte_next   = tx_byte_reg;
        tx_start       = (rep_state_reg == REP_START);
        rep_done       = (rep_state_reg == REP_DONE);
        tx_data        = tx_byte_reg;

        if (!rep_activate) begin
            // A byte already handed to the transmitter keeps going; only
            // this engine returns to idle.
            rep_state_next = REP_IDLE;
            tx_byte_next   = 8'h00;
        end else begin
            case (rep_state_reg)
                REP_IDLE: begin
                    rep_state_next = REP_WAIT_RX;
                end
                REP_WAIT_RX: begin
                    // Bytes arriving in any other state are simply dropped.
                    if (rx_rise) begin
                        tx_byte_next   = rx_data;
                        rep_state_next = REP_WAIT_IDLE;
                    end
                end
                REP_WAIT_IDLE: begin
                    if (!tx_active) begin
                        rep_state_next = REP_START;
                    end
                end
                REP_START: begin
                    rep_state_next = REP_WAIT_DONE;
                end
                REP_WAIT_DONE: begin
                    if (tx_done) begin
                        if (tx_byte_reg == 8'h04) begin
                            rep_state_next = REP_DONE;
                        end else begin
                            rep_state_next = REP_WAIT_RX;
                        end
                    end
                end
                REP_DONE: begin
                    rep_state_next = REP_DONE;
                end
                default: begin
                    rep_state_next = REP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_clear_replay.sv
// ---------------------------------------------------------------------------
// Self-checking bench for adc_clear_replay.
// Honours FAKE_ADC_TRIANGLE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_adc_clear_replay;

    logic       clk = 1'b0;
    logic       reset;
    logic       adc_strobe;
    logic [7:0] adc_data;
    logic       clr_activate;
    logic       clr_done;
    logic       clr_mem_clk;
    logic       clr_mem_we;
    logic [7:0] clr_mem_addr;
    logic [7:0] clr_mem_data;
    logic       rep_activate;
    logic       rep_done;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_active;
    logic       tx_done;

    always #10 clk = ~clk;

    adc_clear_replay dut (
        .clk          (clk),
        .reset        (reset),
        .adc_strobe   (adc_strobe),
        .adc_data     (adc_data),
        .clr_activate (clr_activate),
        .clr_done     (clr_done),
        .clr_mem_clk  (clr_mem_clk),
        .clr_mem_we   (clr_mem_we),
        .clr_mem_addr (clr_mem_addr),
        .clr_mem_data (clr_mem_data),
        .rep_activate (rep_activate),
        .rep_done     (rep_done),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_active    (tx_active),
        .tx_done      (tx_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Replay scoreboard: bytes the replayer is expected to echo, in order.
    logic [7:0] exp_q[$];

    typedef struct {
        logic       strobe;
        logic [7:0] exp_adc;
    } adc_vec_t;

    adc_vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ADC reference: value after n strobes, straight from the waveform shape.
    function automatic logic [7:0] adc_model(input int n);
`ifdef FAKE_ADC_TRIANGLE_EN
        int p;
        p = n % 510;
        return 8'((p <= 255) ? p : (510 - p));
`else
        return 8'(n % 256);
`endif
    endfunction

    task automatic idle_inputs();
        adc_strobe   = 1'b0;
        clr_activate = 1'b0;
        rep_activate = 1'b0;
        rx_data      = 8'h00;
        rx_ready     = 1'b0;
        tx_active    = 1'b0;
        tx_done      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_tx_start(output int cycles);
        cycles = 0;
        while (!tx_start && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    // One replay transaction with a simple transmitter model: busy for
    // 'busy' cycles after tx_start, then a tx_done pulse. Optionally inject
    // a junk byte while the transmitter is busy; it must be dropped.
    task automatic uart_byte(input logic [7:0] b, input int busy, input bit junk);
        int c;
        logic [7:0] exp_b;
        exp_q.push_back(b);
        send_rx(b);
        wait_tx_start(c);
        check("tx_start_timeout", 32'(c < 100), 32'd1);
        exp_b = exp_q.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, exp_b});
        $display("replay: sent 0x%02h echoed 0x%02h busy=%0d junk=%0d", b, tx_data, busy, junk);
        tick();
        check("tx_start_width", {31'd0, tx_start}, 32'd0);
        tx_active = 1'b1;
        for (int i = 0; i < busy; i++) begin
            if (junk && i == 0) begin
                rx_data  = ~b;
                rx_ready = 1'b1;
            end
            tick();
            rx_ready = 1'b0;
        end
        tx_active = 1'b0;
        tx_done   = 1'b1;
        tick();
        tx_done   = 1'b0;
        check("rep_done_after_byte", {31'd0, rep_done}, {31'd0, (b == 8'h04)});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_spurious_start", {31'd0, tx_start}, 32'd0);
        end
    endtask

    initial begin
        int         n;
        int         k;
        int         pulses;
        int         c;
        int         starts;
        bit         found;
        bit         pend;
        logic       s;
        logic [7:0] b;
        logic [7:0] exp_300;

        vecs[0] = '{1'b1, 8'h01};
        vecs[1] = '{1'b1, 8'h02};
        vecs[2] = '{1'b0, 8'h02};
        vecs[3] = '{1'b1, 8'h03};
        vecs[4] = '{1'b0, 8'h03};
        vecs[5] = '{1'b0, 8'h03};
        vecs[6] = '{1'b1, 8'h04};
        vecs[7] = '{1'b1, 8'h05};
        vecs[8] = '{1'b1, 8'h06};
        vecs[9] = '{1'b0, 8'h06};

        // ---- Reset overrides every input ----
        reset        = 1'b0;
        adc_strobe   = 1'b1;
        clr_activate = 1'b1;
        rep_activate = 1'b1;
        rx_data      = 8'hFF;
        rx_ready     = 1'b1;
        tx_active    = 1'b1;
        tx_done      = 1'b1;
        tick();
        tick();
        check("rst_adc", {24'd0, adc_data}, 32'd0);
        check("rst_clr_done", {31'd0, clr_done}, 32'd0);
        check("rst_mem_we", {31'd0, clr_mem_we}, 32'd0);
        check("rst_mem_clk", {31'd0, clr_mem_clk}, 32'd0);
        check("rst_mem_addr", {24'd0, clr_mem_addr}, 32'd0);
        check("rst_mem_data", {24'd0, clr_mem_data}, 32'd0);
        check("rst_rep_done", {31'd0, rep_done}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        do_reset();

        // ---- Table-driven ADC steps ----
        for (int i = 0; i < 10; i++) begin
            adc_strobe = vecs[i].strobe;
            tick();
            check("adc_table", {24'd0, adc_data}, {24'd0, vecs[i].exp_adc});
        end
        adc_strobe = 1'b0;

        // ---- 300 strobes from reset ----
`ifdef FAKE_ADC_TRIANGLE_EN
        exp_300 = 8'hD2;
`else
        exp_300 = 8'h2C;
`endif
        do_reset();
        adc_strobe = 1'b1;
        repeat (300) tick();
        adc_strobe = 1'b0;
        check("adc_300", {24'd0, adc_data}, {24'd0, exp_300});
        $display("adc: 300 strobes -> 0x%02h", adc_data);

        // ---- Random ADC strobes against the reference ----
        do_reset();
        n = 0;
        for (int i = 0; i < 1200; i++) begin
            s = 1'($urandom_range(0, 1));
            adc_strobe = s;
            tick();
            n += int'(s);
            check("adc_random", {24'd0, adc_data}, {24'd0, adc_model(n)});
        end
        adc_strobe = 1'b0;
        $display("adc: random run, %0d strobes", n);

        // ---- Full clear with fill 0xA5 ----
        do_reset();
        clr_activate = 1'b1;
        tick();
        tick();
        check("clr_no_write_before_fill", {31'd0, clr_mem_we}, 32'd0);
        send_rx(8'hA5);
        k = 0;
        pulses = 0;
        while (!clr_done && k < 2000) begin
            tick();
            k++;
            if (clr_mem_clk) begin
                check("clr_addr", {24'd0, clr_mem_addr}, 32'(pulses));
                check("clr_data", {24'd0, clr_mem_data}, 32'h0000_00A5);
                check("clr_we_at_strobe", {31'd0, clr_mem_we}, 32'd1);
                pulses++;
            end
        end
        check("clr_done_latency", 32'(k), 32'd512);
        check("clr_pulse_count", 32'(pulses), 32'd256);
        $display("clear: fill 0xA5, %0d writes, done after %0d cycles", pulses, k);
        repeat (3) begin
            tick();
            check("clr_done_held", {31'd0, clr_done}, 32'd1);
            check("clr_done_we", {31'd0, clr_mem_we}, 32'd0);
            check("clr_done_memclk", {31'd0, clr_mem_clk}, 32'd0);
        end
        clr_activate = 1'b0;
        tick();
        check("clr_done_release", {31'd0, clr_done}, 32'd0);

        // ---- Clear aborted at address 0x40 ----
        clr_activate = 1'b1;
        tick();
        send_rx(8'h3C);
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick();
            if (clr_mem_we && clr_mem_addr == 8'h40) found = 1'b1;
        end
        check("clr_reached_0x40", {31'd0, found}, 32'd1);
        clr_activate = 1'b0;
        tick();
        check("abort_we", {31'd0, clr_mem_we}, 32'd0);
        check("abort_memclk", {31'd0, clr_mem_clk}, 32'd0);
        check("abort_addr", {24'd0, clr_mem_addr}, 32'd0);
        check("abort_data", {24'd0, clr_mem_data}, 32'd0);
        check("abort_done", {31'd0, clr_done}, 32'd0);
        $display("clear: aborted at addr 0x40");
        clr_activate = 1'b1;
        c = 0;
        repeat (20) begin
            tick();
            if (clr_mem_we) c++;
        end
        check("reactivate_needs_fill", 32'(c), 32'd0);
        send_rx(8'h77);
        k = 0;
        while (!clr_mem_clk && k < 10) begin
            tick();
            k++;
        end
        check("refill_first_addr", {24'd0, clr_mem_addr}, 32'd0);
        check("refill_data", {24'd0, clr_mem_data}, 32'h0000_0077);
        clr_activate = 1'b0;
        tick();

        // ---- Replay 0x41, 0x42, 0x04 ----
        do_reset();
        rep_activate = 1'b1;
        tick();
        uart_byte(8'h41, 5, 1'b0);
        uart_byte(8'h42, 3, 1'b0);
        uart_byte(8'h04, 2, 1'b0);
        check("rep_done_held", {31'd0, rep_done}, 32'd1);
        rep_activate = 1'b0;
        tick();
        check("rep_done_release", {31'd0, rep_done}, 32'd0);
        check("rep_tx_data_cleared", {24'd0, tx_data}, 32'd0);

        // ---- Random replay traffic with dropped junk bytes ----
        rep_activate = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h04) b = 8'h05;
            uart_byte(b, int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)));
        end

        // ---- Transmitter busy for 50 cycles with a byte pending ----
        tx_active = 1'b1;
        send_rx(8'h55);
        starts = 0;
        repeat (50) begin
            tick();
            if (tx_start) starts++;
        end
        check("busy_no_start", 32'(starts), 32'd0);
        tx_active = 1'b0;
        tick();
        check("start_after_busy", {31'd0, tx_start}, 32'd1);
        check("start_after_busy_data", {24'd0, tx_data}, 32'h0000_0055);
        $display("replay: 0x55 held by busy transmitter, echoed 0x%02h", tx_data);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;

        // ---- rx_ready held high for 10 cycles ----
        rx_data  = 8'h66;
        rx_ready = 1'b1;
        starts   = 0;
        pend     = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            tx_done = 1'b0;
            if (i == 9) rx_ready = 1'b0;
            if (pend) begin
                tx_done = 1'b1;
                pend    = 1'b0;
            end
            if (tx_start) begin
                starts++;
                pend = 1'b1;
            end
        end
        tx_done = 1'b0;
        check("held_rx_single_echo", 32'(starts), 32'd1);
        $display("replay: rx_ready held 10 cycles, %0d echo(es)", starts);
        uart_byte(8'h04, 4, 1'b0);

        // ---- Replay abort while waiting for tx_done ----
        rep_activate = 1'b0;
        tick();
        rep_activate = 1'b1;
        tick();
        send_rx(8'h99);
        wait_tx_start(c);
        check("abort_rep_start_seen", 32'(c < 100), 32'd1);
        tick();
        rep_activate = 1'b0;
        tick();
        check("rep_abort_tx_data", {24'd0, tx_data}, 32'd0);
        check("rep_abort_tx_start", {31'd0, tx_start}, 32'd0);
        check("rep_abort_done", {31'd0, rep_done}, 32'd0);
        $display("replay: aborted while waiting for tx_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
